kfps2_frame_receiver: RTL



---
 rtl/kfps2_frame_receiver.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/kfps2_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : kfps2_frame_receiver
// Description : PS/2 device-to-host frame receiver. Synchronises and
//               deglitches the raw PS/2 lines, deserialises frames of
//               configurable width and parity, aborts stalled frames on
//               timeout and buffers good bytes in a valid/ready FIFO.
//               All state advances on the falling edge of the system clock.
// Revision    : 1.0 - initial release
// ============================================================================
module kfps2_frame_receiver #(
    parameter int DATA_WIDTH     = 8,
    parameter int PARITY_MODE    = 1,
    parameter int FILTER_LENGTH  = 4,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  device_clock,
    input  logic                  device_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  timeout_error,
    output logic                  overflow_flag,
    output logic                  busy
);

    localparam int c_FILT_W = 4;
    localparam int c_TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Synchroniser and glitch filter
    // ------------------------------------------------------------------
    logic                r_clk_meta;
    logic                r_clk_sync;
    logic                r_dat_meta;
    logic                r_dat_sync;
    logic                r_filt_clk;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                w_filt_diff;
    logic                w_filt_toggle;
    logic                w_fall;

    assign w_filt_diff   = (r_clk_sync != r_filt_clk);
    // The toggle fires on the cycle the run of differing samples reaches FILTER_LENGTH
    assign w_filt_toggle = w_filt_diff && (r_filt_cnt == c_FILT_W'(FILTER_LENGTH - 1));
    assign w_fall        = w_filt_toggle && r_filt_clk;

    // Two-flop synchronisers; idle-high lines so they reset to 1
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= device_clock;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= device_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Filtered clock changes only after FILTER_LENGTH consecutive differing samples
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_filt_toggle) begin
            r_filt_clk <= ~r_filt_clk;
            r_filt_cnt <= '0;
        end else if (w_filt_diff) begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end else begin
            r_filt_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, timeout and frame evaluation
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [c_BIT_W-1:0]    r_bit_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity_bit;
    logic [c_TMR_W-1:0]    r_timer;
    logic                  r_parity_error;
    logic                  r_framing_error;
    logic                  r_timeout_error;
    logic                  w_stop_fall;
    logic                  w_parity_ok;
    logic                  w_push;
    logic                  w_timeout;

    assign w_stop_fall = w_fall && (r_state == c_ST_STOP);
    // Mode 1 wants an odd total of ones across data+parity, mode 2 an even total
    assign w_parity_ok = (PARITY_MODE == 0) || ((^r_shift ^ r_parity_bit) == (PARITY_MODE == 1));
    // Stop bit is the data sample taken with the stop-bit fall
    assign w_push      = w_stop_fall && w_parity_ok && r_dat_sync;
    // Timer reaches TIMEOUT_CYCLES on this edge unless a fall restarts it
    assign w_timeout   = (r_state != c_ST_IDLE) && !w_fall &&
                         (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));

    // Frame state machine with timeout abort and registered error pulses
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_bit_count     <= '0;
            r_shift         <= '0;
            r_parity_bit    <= 1'b0;
            r_timer         <= '0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_timeout_error <= 1'b0;
        end else begin
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_timeout_error <= 1'b0;

            if ((r_state == c_ST_IDLE) || w_fall) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_timeout) begin
                r_state         <= c_ST_IDLE;
                r_timer         <= '0;
                r_timeout_error <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (!r_dat_sync) begin
                            r_state     <= c_ST_DATA;
                            r_bit_count <= '0;
                        end
                    end
                    c_ST_DATA: begin
                        r_shift     <= {r_dat_sync, r_shift[DATA_WIDTH-1:1]};
                        r_bit_count <= r_bit_count + 1'b1;
                        if (r_bit_count == c_BIT_W'(DATA_WIDTH - 1)) begin
                            r_state <= (PARITY_MODE != 0) ? c_ST_PARITY : c_ST_STOP;
                        end
                    end
                    c_ST_PARITY: begin
                        r_parity_bit <= r_dat_sync;
                        r_state      <= c_ST_STOP;
                    end
                    c_ST_STOP: begin
                        r_state         <= c_ST_IDLE;
                        r_parity_error  <= !w_parity_ok;
                        r_framing_error <= !r_dat_sync;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr_en;

    assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop   = (r_count != '0) && data_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr_en = w_push && (!w_full || w_pop);

    // FIFO storage, pointers and occupancy; overflow pulses when a good frame is dropped
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out      = r_mem[r_rd_ptr];
    assign data_valid    = (r_count != '0);
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign timeout_error = r_timeout_error;
    assign overflow_flag = r_overflow;
    assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
